// File: rtl/rx_bitclk_scheduler_pkg.sv
// Shared eUSCI receive-path constants: scheduler state encodings, counter width,
// oversampling factor and the shadowed baud configuration record.
package rx_bitclk_scheduler_pkg;

    localparam int CNT_W       = 21;
    localparam int OS16_FACTOR = 16;

    localparam logic [1:0] sIDLE = 2'd0;
    localparam logic [1:0] sHALF = 2'd1;
    localparam logic [1:0] sRUN  = 2'd2;

    typedef struct packed {
        logic [15:0] br;
        logic        os16;
        logic [3:0]  brf;
        logic [7:0]  brs;
    } baud_cfg_t;

endpackage

// File: rtl/rx_sync2.sv
// Two-flop synchroniser for the asynchronous Rx pin; resets to the idle-high level.
module rx_sync2 (
    input  logic MCLK,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/rx_bitclk_scheduler.sv
// UART receive baud scheduler: start-bit detection with glitch rejection and
// mid-bit BITCLK generation using eUSCI prescale/oversampling/modulation.
module rx_bitclk_scheduler
    import rx_bitclk_scheduler_pkg::*;
#(
    parameter int CNT_W = rx_bitclk_scheduler_pkg::CNT_W
) (
    input  logic        MCLK,
    input  logic        reset,
    input  logic        wUCSWRST,
    input  logic [15:0] wUCBR,
    input  logic        wUCOS16,
    input  logic [3:0]  wUCBRF,
    input  logic [7:0]  wUCBRS,
    input  logic        Rx,
    input  logic        RxBusy,
    output logic        BITCLK,
    output logic        RxSync,
    output logic        SchedBusy,
    output logic        rGlitch
);

    function automatic logic [CNT_W-1:0] calc_base(input baud_cfg_t cfg);
        logic [CNT_W-1:0] br;
        br = (cfg.br == 16'd0) ? CNT_W'(1) : CNT_W'(cfg.br);
        return cfg.os16 ? CNT_W'(br * CNT_W'(OS16_FACTOR)) : br;
    endfunction

    function automatic logic [CNT_W-1:0] calc_half(input baud_cfg_t cfg);
        logic [CNT_W-1:0] h;
        h = calc_base(cfg) >> 1;
        return (h == '0) ? CNT_W'(1) : h;
    endfunction

    // Modulation bit is picked by the index of the bit whose sample starts the period.
    function automatic logic [CNT_W-1:0] calc_period(input baud_cfg_t cfg, input logic [2:0] idx);
        logic [CNT_W-1:0] p;
        p = calc_base(cfg) + CNT_W'(cfg.brs[idx]);
        if (cfg.os16) begin
            p = p + CNT_W'(cfg.brf);
        end
        return (p < CNT_W'(2)) ? CNT_W'(2) : p;
    endfunction

    logic             rx_sync;
    baud_cfg_t        cfg_live;
    logic [CNT_W-1:0] half_live;
    logic [CNT_W-1:0] period_run;

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]       idx_q,    idx_d;
    baud_cfg_t        cfg_q,    cfg_d;
    logic             bitclk_q, bitclk_d;
    logic             glitch_q, glitch_d;

    rx_sync2 u_sync (
        .MCLK  (MCLK),
        .reset (reset),
        .d_i   (Rx),
        .q_o   (rx_sync)
    );

    assign cfg_live   = '{br: wUCBR, os16: wUCOS16, brf: wUCBRF, brs: wUCBRS};
    assign half_live  = calc_half(cfg_live);
    assign period_run = calc_period(cfg_q, idx_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        cfg_d    = cfg_q;
        bitclk_d = 1'b0;
        glitch_d = 1'b0;

        case (state_q)
            sIDLE: begin
                if (!rx_sync) begin
                    state_d = sHALF;
                    cnt_d   = half_live - CNT_W'(1);
                    idx_d   = 3'd0;
                    cfg_d   = cfg_live;
                end
            end
            sHALF: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!rx_sync) begin
                    bitclk_d = 1'b1;
                    cnt_d    = period_run - CNT_W'(1);
                    idx_d    = 3'(idx_q + 3'd1);
                    state_d  = sRUN;
                end else begin
                    glitch_d = 1'b1;
                    state_d  = sIDLE;
                end
            end
            sRUN: begin
                // RxBusy is only meaningful one cycle after a BITCLK rise.
                if (bitclk_q && !RxBusy) begin
                    state_d = sIDLE;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                end else if (cnt_q == '0) begin
                    bitclk_d = 1'b1;
                    cnt_d    = period_run - CNT_W'(1);
                    idx_d    = 3'(idx_q + 3'd1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = sIDLE;
                cnt_d   = '0;
                idx_d   = 3'd0;
            end
        endcase

        if (wUCSWRST) begin
            state_d  = sIDLE;
            cnt_d    = '0;
            idx_d    = 3'd0;
            bitclk_d = 1'b0;
            glitch_d = 1'b0;
        end
    end

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            state_q  <= sIDLE;
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            cfg_q    <= '0;
            bitclk_q <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            cfg_q    <= cfg_d;
            bitclk_q <= bitclk_d;
            glitch_q <= glitch_d;
        end
    end

    assign BITCLK    = bitclk_q;
    assign RxSync    = rx_sync;
    assign SchedBusy = (state_q != sIDLE);
    assign rGlitch   = glitch_q;

endmodule

// File: tb/tb_rx_bitclk_scheduler.sv
// Bench for rx_bitclk_scheduler: 8N1 frames from a config table with a queue of
// expected BITCLK times, a tiny receive-state-machine model, and corner sequences.
module tb_rx_bitclk_scheduler;

    typedef struct {
        logic [15:0] br;
        logic        os16;
        logic [3:0]  brf;
        logic [7:0]  brs;
        logic [7:0]  data;
        int          first;
        int          p0;
        int          p1;
    } vec_t;

    logic        MCLK;
    logic        reset;
    logic        wUCSWRST;
    logic [15:0] wUCBR;
    logic        wUCOS16;
    logic [3:0]  wUCBRF;
    logic [7:0]  wUCBRS;
    logic        Rx;
    logic        RxBusy;
    logic        BITCLK;
    logic        RxSync;
    logic        SchedBusy;
    logic        rGlitch;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   drive_cyc = 0;
    logic t0_armed = 1'b0;
    int   exp_q[$];
    int   last_off = 0;
    logic model_en = 1'b0;
    int   pulse_cnt = 0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_shift = 8'h00;
    logic stop_bit = 1'b0;
    logic prev_bitclk = 1'b0;
    logic prev_sb = 1'b0;
    int   sb_fall = -1;
    int   glitch_cnt = 0;
    int   glitch_cyc = -1;
    vec_t vecs[7];

    rx_bitclk_scheduler dut (
        .MCLK      (MCLK),
        .reset     (reset),
        .wUCSWRST  (wUCSWRST),
        .wUCBR     (wUCBR),
        .wUCOS16   (wUCOS16),
        .wUCBRF    (wUCBRF),
        .wUCBRS    (wUCBRS),
        .Rx        (Rx),
        .RxBusy    (RxBusy),
        .BITCLK    (BITCLK),
        .RxSync    (RxSync),
        .SchedBusy (SchedBusy),
        .rGlitch   (rGlitch)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;
    always @(posedge MCLK) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name, input int act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %0d, expected nothing (cycle %0d)", name, act, cyc);
    endtask

    // One negedge step: scoreboard on BITCLK rises plus the receive state machine model.
    task automatic tick();
        @(negedge MCLK);
        if (t0_armed && !RxSync) begin
            t0 = cyc;
            t0_armed = 1'b0;
        end
        if (BITCLK) begin
            check("bitclk_width", int'(prev_bitclk), 0);
            if (!prev_bitclk) begin
                if (exp_q.size() == 0) fail_evt("bitclk_unexpected", cyc - t0);
                else check("bitclk_time", cyc - t0, exp_q.pop_front());
                if (model_en) begin
                    if (pulse_cnt == 0) begin
                        check("start_bit", int'(RxSync), 0);
                        RxBusy = 1'b1;
                    end else if (pulse_cnt <= 8) begin
                        rx_shift = {RxSync, rx_shift[7:1]};
                    end else if (pulse_cnt == 9) begin
                        stop_bit = RxSync;
                        RxBusy = 1'b0;
                    end
                    Rx = (pulse_cnt < 8) ? tx_data[pulse_cnt] : 1'b1;
                    pulse_cnt++;
                end
            end
        end
        if (prev_sb && !SchedBusy) sb_fall = cyc;
        if (rGlitch) begin
            glitch_cnt++;
            glitch_cyc = cyc;
        end
        prev_bitclk = BITCLK;
        prev_sb = SchedBusy;
    endtask

    task automatic start_frame(input vec_t v);
        int off;
        wUCBR = v.br;
        wUCOS16 = v.os16;
        wUCBRF = v.brf;
        wUCBRS = v.brs;
        exp_q.delete();
        off = v.first;
        exp_q.push_back(off);
        for (int k = 1; k < 10; k++) begin
            off = off + (v.brs[(k - 1) % 8] ? v.p1 : v.p0);
            exp_q.push_back(off);
        end
        last_off = off;
        pulse_cnt = 0;
        tx_data = v.data;
        rx_shift = 8'h00;
        stop_bit = 1'b0;
        sb_fall = -1;
        glitch_cnt = 0;
        model_en = 1'b1;
        repeat (3) tick();
        t0_armed = 1'b1;
        drive_cyc = cyc;
        Rx = 1'b0;
    endtask

    task automatic wait_pulses(input int n);
        int budget;
        budget = 0;
        while (pulse_cnt < n && budget < 3000) begin
            tick();
            budget++;
        end
        if (pulse_cnt < n) check("pulse_timeout", pulse_cnt, n);
    endtask

    task automatic run_frame(input vec_t v, input int chg_at, input logic [15:0] chg_br);
        int budget;
        start_frame(v);
        budget = 0;
        while (!(pulse_cnt == 10 && !SchedBusy) && budget < 3000) begin
            tick();
            if (chg_at >= 0 && pulse_cnt == chg_at) wUCBR = chg_br;
            budget++;
        end
        if (budget >= 3000) check("frame_timeout", pulse_cnt, 10);
        repeat (5) tick();
        model_en = 1'b0;
        check("sync_latency", t0 - drive_cyc, 2);
        check("pulse_count", pulse_cnt, 10);
        check("pulses_left", exp_q.size(), 0);
        check("rx_data", int'(rx_shift), int'(v.data));
        check("stop_bit", int'(stop_bit), 1);
        check("sched_fall", sb_fall - t0, last_off + 1);
        check("no_glitch", glitch_cnt, 0);
        $display("frame br=%0d os16=%0d brf=%0d brs=%02h: rx=%02h first=%0d fall=%0d",
                 v.br, v.os16, v.brf, v.brs, rx_shift, v.first, sb_fall - t0);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{16'd4, 1'b0, 4'd0,  8'h00, 8'h55, 3,  4,  5};
        vecs[1] = '{16'd4, 1'b0, 4'd0,  8'h01, 8'hA3, 3,  4,  5};
        vecs[2] = '{16'd1, 1'b1, 4'd2,  8'h00, 8'h0F, 9,  18, 19};
        vecs[3] = '{16'd0, 1'b0, 4'd0,  8'h00, 8'hC4, 2,  2,  2};
        vecs[4] = '{16'd1, 1'b0, 4'd5,  8'hAA, 8'h3C, 2,  2,  2};
        vecs[5] = '{16'd3, 1'b1, 4'd15, 8'h80, 8'h81, 25, 63, 64};
        vecs[6] = '{16'd5, 1'b0, 4'd0,  8'h24, 8'h96, 3,  5,  6};

        reset = 1'b1;
        wUCSWRST = 1'b0;
        wUCBR = 16'd4;
        wUCOS16 = 1'b0;
        wUCBRF = 4'd0;
        wUCBRS = 8'h00;
        Rx = 1'b1;
        RxBusy = 1'b0;
        repeat (3) @(negedge MCLK);
        check("reset_bitclk", int'(BITCLK), 0);
        check("reset_busy", int'(SchedBusy), 0);
        check("reset_glitch", int'(rGlitch), 0);
        check("reset_rxsync", int'(RxSync), 1);
        reset = 1'b0;
        repeat (3) tick();
        check("idle_busy", int'(SchedBusy), 0);

        for (int i = 0; i < 7; i++) run_frame(vecs[i], -1, 16'd0);

        // Glitch: RxSync low for only two cycles with H=4.
        wUCBR = 16'd8;
        wUCOS16 = 1'b0;
        wUCBRS = 8'h00;
        exp_q.delete();
        glitch_cnt = 0;
        tick();
        t0_armed = 1'b1;
        drive_cyc = cyc;
        Rx = 1'b0;
        tick();
        tick();
        Rx = 1'b1;
        repeat (20) tick();
        check("glitch_latency", t0 - drive_cyc, 2);
        check("glitch_count", glitch_cnt, 1);
        check("glitch_time", glitch_cyc - t0, 5);
        check("glitch_idle", int'(SchedBusy), 0);
        $display("glitch: pulses=%0d at t0+%0d", glitch_cnt, glitch_cyc - t0);

        // Prescaler rewritten mid-frame; the following frame picks it up.
        run_frame(vecs[0], 4, 16'd8);
        v = '{16'd8, 1'b0, 4'd0, 8'h00, 8'h69, 5, 8, 9};
        run_frame(v, -1, 16'd0);

        // Software reset coinciding with the counter expiring after the 4th data bit.
        v = '{16'd4, 1'b0, 4'd0, 8'h00, 8'h00, 3, 4, 5};
        start_frame(v);
        wait_pulses(5);
        model_en = 1'b0;
        repeat (3) tick();
        wUCSWRST = 1'b1;
        tick();
        check("swrst_bitclk", int'(BITCLK), 0);
        check("swrst_busy", int'(SchedBusy), 0);
        check("swrst_rxsync", int'(RxSync), 0);
        Rx = 1'b1;
        RxBusy = 1'b0;
        repeat (4) tick();
        wUCSWRST = 1'b0;
        repeat (30) tick();
        check("swrst_no_more_pulses", exp_q.size(), 5);
        check("swrst_idle", int'(SchedBusy), 0);
        $display("swrst: pending pulses dropped=%0d", exp_q.size());
        exp_q.delete();

        // Asynchronous reset while BITCLK is high.
        start_frame(v);
        wait_pulses(5);
        model_en = 1'b0;
        check("pre_reset_bitclk", int'(BITCLK), 1);
        reset = 1'b1;
        #1;
        check("areset_bitclk", int'(BITCLK), 0);
        check("areset_busy", int'(SchedBusy), 0);
        check("areset_rxsync", int'(RxSync), 1);
        Rx = 1'b1;
        RxBusy = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        check("post_reset_rxsync", int'(RxSync), 1);
        check("post_reset_busy", int'(SchedBusy), 0);
        $display("areset: busy=%0d rxsync=%0d", SchedBusy, RxSync);
        exp_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
